pci_rx_packetizer: RTL

Device-side receiver for the 8-bit PCIe byte stream that the host pushes into `procTop` (`i_valid_pci`/`i_data_pci`/`o_ready_pci`). It packs `BYTES_PER_FLIT` consecutive bytes into one NoC flit, prepends a destination (x,y) header, and hands flits to the NoC injection port of the PCIe-attached node. Destinations are assigned round-robin over every PE except the PCIe node itself, so image data is spread evenly across the mesh.

---
 rtl/pci_rx_packetizer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pci_rx_packetizer.sv
// -----------------------------------------------------------------------------
// pci_rx_packetizer
//
// Packs the 8-bit PCIe receive byte stream into NoC flits. BYTES_PER_FLIT
// consecutive bytes form one data word, with the first byte in the LSB lane.
// Each completed word is stamped with a destination (x,y) and presented on the
// NoC injection port. Destinations rotate in raster order (x fastest) over
// every mesh node except the PCIe-attached node (SRC_X,SRC_Y).
//
// Ports:
//   clk          in   clock, rising edge
//   rstn         in   asynchronous active-low reset
//   i_valid_pci  in   input byte valid
//   i_data_pci   in   input byte
//   o_ready_pci  out  a byte can be accepted this cycle
//   o_valid_noc  out  output flit valid
//   o_data_noc   out  {data, dest_y, dest_x}
//   i_ready_noc  in   NoC accepts the flit this cycle
//   o_flit_count out  flits accepted by the NoC since reset (wraps)
// -----------------------------------------------------------------------------
module pci_rx_packetizer #(
  parameter int X              = 2,
  parameter int Y              = 2,
  parameter int X_SIZE         = 1,
  parameter int Y_SIZE         = 1,
  parameter int BYTES_PER_FLIT = 4,
  parameter int SRC_X          = 0,
  parameter int SRC_Y          = 0,
  localparam int DATA_WIDTH    = 8 * BYTES_PER_FLIT,
  localparam int FLIT_W        = DATA_WIDTH + Y_SIZE + X_SIZE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_valid_pci,
  input  logic [7:0]        i_data_pci,
  output logic              o_ready_pci,
  output logic              o_valid_noc,
  output logic [FLIT_W-1:0] o_data_noc,
  input  logic              i_ready_noc,
  output logic [31:0]       o_flit_count
);

  localparam int CNT_W = $clog2(BYTES_PER_FLIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_FLIT - 1);

  localparam logic [X_SIZE-1:0] SRC_XV  = X_SIZE'(SRC_X);
  localparam logic [Y_SIZE-1:0] SRC_YV  = Y_SIZE'(SRC_Y);
  localparam logic [X_SIZE-1:0] LAST_XV = X_SIZE'(X - 1);
  localparam logic [Y_SIZE-1:0] LAST_YV = Y_SIZE'(Y - 1);

  // First node in raster order from (0,0) that is not the source node.
  localparam bit SRC_AT_ORIGIN = (SRC_X == 0) && (SRC_Y == 0);
  localparam logic [X_SIZE-1:0] FIRST_X =
    (SRC_AT_ORIGIN && X > 1) ? X_SIZE'(1) : X_SIZE'(0);
  localparam logic [Y_SIZE-1:0] FIRST_Y =
    (SRC_AT_ORIGIN && X == 1) ? Y_SIZE'(1) : Y_SIZE'(0);

  typedef struct packed {
    logic [Y_SIZE-1:0] y;
    logic [X_SIZE-1:0] x;
  } coord_t;

  // One raster step: x fastest, wrapping (X-1,Y-1) back to (0,0).
  function automatic coord_t raster_step(input coord_t c);
    coord_t n;
    n = c;
    if (c.x == LAST_XV) begin
      n.x = '0;
      n.y = (c.y == LAST_YV) ? '0 : c.y + Y_SIZE'(1);
    end else begin
      n.x = c.x + X_SIZE'(1);
    end
    return n;
  endfunction

  logic [DATA_WIDTH-1:0] pack_reg;
  logic [CNT_W-1:0]      pack_cnt;
  coord_t                dest;
  coord_t                dest_next;
  logic [DATA_WIDTH-1:0] word;
  logic                  accept;
  logic                  send;
  logic                  load;

  // A completing byte may enter only if the output register is free now or
  // is being drained on this same edge.
  assign o_ready_pci = !o_valid_noc || i_ready_noc || (pack_cnt != LAST_CNT);
  assign accept      = i_valid_pci && o_ready_pci;
  assign send        = o_valid_noc && i_ready_noc;
  assign load        = accept && (pack_cnt == LAST_CNT);

  // NOTE: every signal driven here gets a value before any branch so that no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    word                      = pack_reg;
    word[DATA_WIDTH-1 -: 8]   = i_data_pci;
    dest_next                 = raster_step(dest);
    if (dest_next.x == SRC_XV && dest_next.y == SRC_YV) begin
      dest_next = raster_step(dest_next);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and the result does not depend on process order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pack_reg <= '0;
      pack_cnt <= '0;
    end else if (accept) begin
      if (load) begin
        pack_cnt <= '0;
      end else begin
        pack_reg[8*pack_cnt +: 8] <= i_data_pci;
        pack_cnt                  <= pack_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_valid_noc <= 1'b0;
      o_data_noc  <= '0;
      dest.x      <= FIRST_X;
      dest.y      <= FIRST_Y;
    end else if (load) begin
      o_valid_noc <= 1'b1;
      o_data_noc  <= {word, dest.y, dest.x};
      dest        <= dest_next;
    end else if (send) begin
      o_valid_noc <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_flit_count <= '0;
    end else if (send) begin
      o_flit_count <= o_flit_count + 32'd1;
    end
  end

endmodule
